// File: rtl/l2_ctrl.sv
// Two-port front end for the direct-mapped L2 data array: round-robin arbitration,
// tag lookup, read-miss refill from memory, write-through stores and hit/miss counters.
module l2_ctrl #(
  parameter int AW    = 64,
  parameter int DW    = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic [AW-1:0]    addr0,
  input  logic [AW-1:0]    addr1,
  input  logic [DW-1:0]    wdata0,
  input  logic [DW-1:0]    wdata1,
  output logic             ack0,
  output logic             ack1,
  output logic [DW-1:0]    rdata_o,
  output logic [AW-1:0]    l2_addr,
  output logic             l2_we,
  output logic [DW-1:0]    l2_wdata,
  input  logic [DW-1:0]    l2_rdata,
  input  logic             l2_hit,
  output logic             mem_req,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic             mem_ack,
  input  logic [DW-1:0]    mem_rdata,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOOKUP  = 3'd1;
  localparam logic [2:0] RD_WAIT = 3'd2;
  localparam logic [2:0] MEM_RD  = 3'd3;
  localparam logic [2:0] FILL    = 3'd4;
  localparam logic [2:0] MEM_WR  = 3'd5;
  localparam logic [2:0] RESP    = 3'd6;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  logic [1:0]    req_v;
  req_t [1:0]    port_req;
  req_t          cur;
  logic          cur_id;
  logic          gnt_id;
  logic          rr_last;
  logic [2:0]    state;
  logic [DW-1:0] resp;

  assign req_v       = {req1, req0};
  assign port_req[0] = {we0, addr0, wdata0};
  assign port_req[1] = {we1, addr1, wdata1};

  // On a tie the port that was not served last wins; otherwise whoever is asking.
  assign gnt_id = (&req_v) ? ~rr_last : req_v[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_last  <= 1'b1;
      cur      <= '0;
      cur_id   <= 1'b0;
      resp     <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (|req_v) begin
          cur    <= port_req[gnt_id];
          cur_id <= gnt_id;
          resp   <= '0;
          state  <= LOOKUP;
        end
        LOOKUP: begin
          if (cur.we) begin
            state <= MEM_WR;
          end else if (l2_hit) begin
            hit_cnt <= hit_cnt + CNT_W'(1);
            state   <= RD_WAIT;
          end else begin
            miss_cnt <= miss_cnt + CNT_W'(1);
            state    <= MEM_RD;
          end
        end
        RD_WAIT: begin
          resp  <= l2_rdata;
          state <= RESP;
        end
        MEM_RD: if (mem_ack) begin
          resp  <= mem_rdata;
          state <= FILL;
        end
        FILL:   state <= RESP;
        MEM_WR: if (mem_ack) state <= RESP;
        RESP: begin
          rr_last <= cur_id;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The latched address only changes on a grant, so it holds its last value in IDLE.
  assign l2_addr   = cur.addr;
  assign l2_we     = (state == LOOKUP && cur.we) || (state == FILL);
  assign l2_wdata  = (state == FILL) ? resp :
                     (state == LOOKUP && cur.we) ? cur.wdata : '0;
  assign mem_req   = (state == MEM_RD) || (state == MEM_WR);
  assign mem_we    = (state == MEM_WR);
  assign mem_addr  = mem_req ? cur.addr : '0;
  assign mem_wdata = (state == MEM_WR) ? cur.wdata : '0;
  assign ack0      = (state == RESP) && !cur_id;
  assign ack1      = (state == RESP) && cur_id;
  assign rdata_o   = (state == RESP) ? resp : '0;
endmodule
